// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - scoreboarded multi-port register file with write bypass and PC mirror
//
// Purpose: integer register file between decode (NRD combinational reads) and
// execute/memory (ALU write port A, load writeback port L). Same-cycle writes
// are bypassed to the read ports, outstanding loads are tracked with per-register
// busy bits, and the top register mirrors the PC with one cycle of latency.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rd_addr_i / rd_data_o  NRD packed read addresses / read data
//   rd_busy_o              per read port: register awaits an outstanding load
//   wa_*                   ALU write port (enable, address, data)
//   wl_*                   load writeback port (enable, address, data)
//   ld_issue_i, ld_addr_i  load issued, destination register becomes busy
//   pc_i                   current PC, sampled every cycle into register NREGS-1
//   busy_cnt_o             registered number of busy registers
//   err_o                  sticky illegal-operation flag

module reg_file_sb #(
  parameter int N     = 32,
  parameter int NREGS = 16,
  parameter int NRD   = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*N-1:0]  rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              wa_en_i,
  input  logic [AW-1:0]     wa_addr_i,
  input  logic [N-1:0]      wa_data_i,
  input  logic              wl_en_i,
  input  logic [AW-1:0]     wl_addr_i,
  input  logic [N-1:0]      wl_data_i,
  input  logic              ld_issue_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [N-1:0]      pc_i,
  output logic [AW:0]       busy_cnt_o,
  output logic              err_o
);

  localparam logic [AW-1:0] TOP = AW'(NREGS - 1);

  // Entry TOP of the array holds the PC mirror; it is only ever loaded from pc_i.
  logic [N-1:0]     regs_q [NREGS];
  logic [N-1:0]     regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic wa_ok, wl_ok, ld_ok;
  logic err_set;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] b);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{AW{1'b0}}, b[i]};
    end
    return c;
  endfunction

  // Operations aimed at the PC mirror are dropped entirely.
  assign wa_ok = wa_en_i    && (wa_addr_i != TOP);
  assign wl_ok = wl_en_i    && (wl_addr_i != TOP);
  assign ld_ok = ld_issue_i && (ld_addr_i != TOP);

  // Error checks look at the busy state before this edge.
  assign err_set = (wa_en_i    && (wa_addr_i == TOP))
                || (wl_en_i    && (wl_addr_i == TOP))
                || (ld_issue_i && (ld_addr_i == TOP))
                || (wl_ok && !busy_q[wl_addr_i])
                || (wa_ok &&  busy_q[wa_addr_i])
                || (wa_ok && wl_ok && (wa_addr_i == wl_addr_i));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    err_d  = err_q | err_set;
    // L first so that A overwrites it on an address conflict.
    if (wl_ok) regs_d[wl_addr_i] = wl_data_i;
    if (wa_ok) regs_d[wa_addr_i] = wa_data_i;
    regs_d[TOP] = pc_i;
    // Clear before set: a new load to the register being written back stays busy.
    if (wl_ok) busy_d[wl_addr_i] = 1'b0;
    if (ld_ok) busy_d[ld_addr_i] = 1'b1;
    busy_d[TOP] = 1'b0;
    cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_cnt_o = cnt_q;
  assign err_o      = err_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr_i[k*AW +: AW];

    assign rd_data_o[k*N +: N] =
        (addr == TOP)                        ? regs_q[TOP] :
        (wa_en_i && (wa_addr_i == addr))     ? wa_data_i   :
        (wl_en_i && (wl_addr_i == addr))     ? wl_data_i   :
                                               regs_q[addr];

    // A writeback landing this cycle already satisfies the reader.
    assign rd_busy_o[k] = (addr != TOP) && busy_q[addr]
                       && !(wl_en_i && (wl_addr_i == addr));
  end

endmodule
